// File: rtl/imem_loader.sv
// Boot-time loader: turns a byte stream (count header + little-endian words)
// into sequential instruction-memory writes and holds the CPU until it finishes.
module imem_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] len;
  logic [1:0]    byte_idx;
  logic          xfer;
  logic [CW-1:0] count_next;

  always_comb begin
    byte_ready = (state == LEN) || (state == DATA);
    busy       = (state == LEN) || (state == DATA) || (state == WRITE);
    cpu_hold   = (state != DONE);
    xfer       = byte_valid && byte_ready;
    count_next = word_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len        <= '0;
      byte_idx   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state      <= LEN;
            word_count <= '0;
            wr_addr    <= '0;
            byte_idx   <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        LEN: begin
          if (xfer) begin
            // Header already bounded by DEPTH before use, so truncation to CW is safe
            len <= CW'(byte_in);
            if (byte_in == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (int'(byte_in) > DEPTH) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            wr_data[8*byte_idx +: 8] <= byte_in;
            byte_idx                 <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              state <= WRITE;
              wr_en <= 1'b1;
            end
          end
        end
        WRITE: begin
          word_count <= count_next;
          wr_addr    <= wr_addr + 1'b1;
          if (count_next == len) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: streams byte sequences and compares the
// observed memory writes and status against a word-list reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  word_count;
  logic        busy, done, error, cpu_hold;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [31:0] obs_addr[$], obs_data[$], exp_addr[$], exp_data[$];
  logic [7:0]  q[$];

  imem_loader #(.DEPTH(128), .ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .word_count(word_count),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_addr.push_back(32'(wr_addr));
      obs_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_byte_ready", 32'(byte_ready), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_word_count", 32'(word_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_cpu_hold", 32'(cpu_hold), 1);
  endtask

  // Called on a falling edge; leaves the bench on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers the bytes of s with random valid gaps; checks write latency and
  // the header-only outcomes one cycle after each relevant transfer.
  task automatic drive_bytes(input logic [7:0] s[$], input int unsigned pct);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    bit last_fourth = 0;
    bit last_hdr = 0;
    bit x;
    while (idx < s.size() && cyc < 20000) begin
      check("wr_en_latency", 32'(wr_en), 32'(last_fourth));
      if (last_hdr && s[0] == 8'd0) check("hdr0_done", 32'(done), 1);
      if (last_hdr && s[0] > 8'd128) check("hdr_big_error", 32'(error), 1);
      byte_valid = ($urandom_range(99) < pct);
      byte_in    = byte_valid ? s[idx] : 8'($urandom);
      x          = byte_valid && byte_ready;
      last_hdr    = x && (idx == 0);
      last_fourth = x && (idx > 0) && (idx % 4 == 0);
      @(posedge clk);
      if (x) idx++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    if (cyc >= 20000) check("stream_timeout", 0, 1);
    check("wr_en_latency", 32'(wr_en), 32'(last_fourth));
    if (last_hdr && s[0] == 8'd0) check("hdr0_done", 32'(done), 1);
    if (last_hdr && s[0] > 8'd128) check("hdr_big_error", 32'(error), 1);
  endtask

  // Reference: word i of the stream goes to address i, bytes little-endian.
  task automatic expect_words(input logic [7:0] s[$], input int unsigned nwords);
    for (int unsigned i = 0; i < nwords; i++) begin
      exp_addr.push_back(32'(i % 128));
      exp_data.push_back({s[4*i+4], s[4*i+3], s[4*i+2], s[4*i+1]});
    end
  endtask

  task automatic compare_writes();
    int unsigned n;
    check("write_count", obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int unsigned i = 0; i < n; i++) begin
      check("write_addr", obs_addr[i], exp_addr[i]);
      check("write_data", obs_data[i], exp_data[i]);
    end
    obs_addr.delete(); obs_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic run_load(input logic [7:0] s[$], input int unsigned pct);
    int unsigned n;
    bit err;
    int unsigned waited = 0;
    n   = s[0];
    err = (n > 128);
    pulse_start();
    check("busy_after_start", 32'(busy), 1);
    check("hold_after_start", 32'(cpu_hold), 1);
    drive_bytes(s, pct);
    while (!(done || error) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("end_done", 32'(done), err ? 0 : 1);
    check("end_error", 32'(error), err ? 1 : 0);
    check("end_cpu_hold", 32'(cpu_hold), err ? 1 : 0);
    check("end_busy", 32'(busy), 0);
    check("end_word_count", 32'(word_count), err ? 0 : n);
    check("end_wr_addr", 32'(wr_addr), err ? 0 : n % 128);
    expect_words(s, err ? 0 : n);
  endtask

  task automatic random_stream(input int unsigned n);
    q.delete();
    q.push_back(8'(n));
    repeat (4 * n) q.push_back(8'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values();

    // Two-instruction example program
    q = '{8'h02, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h02, 8'h52, 8'h00};
    run_load(q, 100);
    check("ex_word0", (obs_data.size() > 0) ? obs_data[0] : 32'hx, 32'h00100513);
    check("ex_word1", (obs_data.size() > 1) ? obs_data[1] : 32'hx, 32'h005202B3);
    compare_writes();

    // Empty program
    q = '{8'h00};
    run_load(q, 100);
    compare_writes();

    // Oversized header, then recovery with a one-word load
    q = '{8'h81};
    run_load(q, 100);
    compare_writes();
    random_stream(1);
    run_load(q, 70);
    compare_writes();

    // Full memory
    random_stream(128);
    run_load(q, 100);
    compare_writes();

    // Random sizes with a gappy source
    for (int k = 0; k < 6; k++) begin
      random_stream($urandom_range(1, 12));
      run_load(q, $urandom_range(25, 90));
      compare_writes();
    end

    // Reset in the middle of the second word
    random_stream(3);
    pulse_start();
    drive_bytes(q[0:6], 100);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_words(q, 1);
    compare_writes();

    random_stream(5);
    run_load(q, 60);
    compare_writes();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the 128-word x 32-bit instruction memory.
- Accepts a byte stream with a valid/ready handshake, for example from a UART receiver. The first byte is a word-count header. Each following group of 4 bytes is assembled into one instruction word, little-endian.
- Each assembled word is written to sequential word addresses starting at 0.
- Holds the CPU in reset until a load completes, so the core never fetches from a partially written memory.

Parameters:
- DEPTH, 128, number of instruction words in memory.
- ADDR_W, 7, word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction-memory write strobe, one cycle per word.
- wr_addr  output  ADDR_W  word address for the write (word-indexed, not byte-indexed).
- wr_data  output  32  assembled instruction word.
- word_count  output  ADDR_W+1  number of words written so far in the current load.
- busy  output  1  high in LEN, DATA or WRITE.
- done  output  1  load finished successfully.
- error  output  1  header exceeded DEPTH.
- cpu_hold  output  1  CPU reset request; high in every state except DONE.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state=IDLE;
  - byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0;
  - busy=0, done=0, error=0, cpu_hold=1.
- A byte transfer occurs on a rising edge where byte_valid && byte_ready. No byte is consumed otherwise, and byte_valid may stay high across cycles.
- All outputs are registered, except byte_ready, busy and cpu_hold, which are decoded directly from state.
- States and transitions:
  - IDLE: byte_ready=0. start → LEN, and clears word_count, wr_addr and the internal byte index.
  - LEN: byte_ready=1. On transfer, latch N=byte_in.
    - N=0 → DONE; no writes occur.
    - N>DEPTH → ERROR.
    - Otherwise → DATA.
  - DATA: byte_ready=1. Each transfer places byte k (k=0..3) into word bits [8k+7:8k]. The transfer of byte 3 → WRITE.
  - WRITE: byte_ready=0. wr_en=1 for exactly this one cycle, with wr_addr and wr_data stable. On exit:
    - word_count increments;
    - wr_addr increments;
    - if word_count (after increment) == N → DONE, else → DATA.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start → LEN, which reasserts cpu_hold and clears done.
  - ERROR: error=1, cpu_hold=1, byte_ready=0. start → LEN and clears error.
- Latency: the wr_en pulse comes exactly 1 cycle after the 4th byte of a word is accepted.
- Minimum word period is 5 cycles: 4 transfers plus 1 WRITE cycle.
- Bytes offered while byte_ready=0 are not consumed and are not lost; the source keeps holding them.
- start asserted during LEN, DATA or WRITE is ignored.
- Pulse from start state: start asserted in the same cycle as a transfer is irrelevant, since byte_ready is never 1 in a start-sensitive state.
- Address arithmetic:
  - wr_addr never exceeds DEPTH-1, because N<=DEPTH is checked at the header.
  - For N=DEPTH, the final write is to address DEPTH-1; wr_addr then wraps to 0, and word_count=DEPTH (hence the ADDR_W+1 width).
- Reset mid-load: immediate return to the reset values. The partial word is discarded, and words already written remain in memory. cpu_hold stays 1.
- Restart after DONE overwrites from address 0. Words beyond the new N keep their old contents.

Test Plan:
- Reset, start, stream {0x02, 0x13,0x05,0x10,0x00, 0xB3,0x02,0x52,0x00} →
  - wr_en at addr 0 with data 0x00100513, then at addr 1 with data 0x005202B3;
  - done=1, cpu_hold=0, word_count=2.
- Header 0x00 → DONE the cycle after the transfer, no wr_en pulse, cpu_hold=0.
- Header 0x81 (129) → error=1, cpu_hold=1, no writes. A new start then accepts header 0x01 and loads normally.
- Header 0x80, 512 data bytes → 128 writes at addresses 0..127, final wr_addr=0, word_count=128, done=1.
- byte_valid toggling randomly, held high through WRITE cycles → no byte dropped or duplicated; data matches a reference model.
- rst_n pulsed low after 2 bytes of word 1 →
  - all outputs return to reset values immediately;
  - a subsequent full load starts at addr 0 and completes correctly.
